// File: rtl/sync_in_decoder_pkg.sv
// Shared types and helpers for the SimuCam external sync-input decoder.
package sync_in_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE_WAIT = 2'd0,
        BLANK     = 2'd1,
        PULSE     = 2'd2
    } state_t;

    localparam int unsigned PULSE_NUM_W = 8;
    localparam int unsigned SAT_W       = 64;

    // Bits needed to hold any value in 0..max_value.
    function automatic int unsigned cnt_clog2(input int unsigned max_value);
        int unsigned w;
        w = 1;
        while ((SAT_W'(1) << w) <= SAT_W'(max_value)) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input logic [SAT_W-1:0] max_value);
        return (value >= max_value) ? max_value : value + SAT_W'(1);
    endfunction

endpackage

// File: rtl/sync_in_filter.sv
// Two-flop synchroniser, glitch filter and edge detect for the raw sync input.
// level_o is normalised so that 1 always means "pulse active".
module sync_in_filter
    import sync_in_decoder_pkg::*;
#(
    parameter bit          ACTIVE_HIGH = 1'b1,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic stable_c
);

    localparam int unsigned FLT_W        = cnt_clog2(FILTER_LEN);
    localparam logic        INACTIVE_RAW = ACTIVE_HIGH ? 1'b0 : 1'b1;

    logic             sync_ff1;
    logic             sync_ff2;
    logic             level_q;
    logic             sample_act;
    logic [FLT_W-1:0] flt_cnt;

    assign sample_act = ACTIVE_HIGH ? sync_ff2 : ~sync_ff2;
    assign stable_c   = (sample_act == level_o);

    // Level flips only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_ff1 <= INACTIVE_RAW;
            sync_ff2 <= INACTIVE_RAW;
            level_o  <= 1'b0;
            level_q  <= 1'b0;
            rise_o   <= 1'b0;
            fall_o   <= 1'b0;
            flt_cnt  <= '0;
        end else begin
            sync_ff1 <= sync_in;
            sync_ff2 <= sync_ff1;
            level_q  <= level_o;
            rise_o   <= level_o & ~level_q;
            fall_o   <= ~level_o & level_q;
            if (sample_act == level_o) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                level_o <= sample_act;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + FLT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sync_in_decoder.sv
// Receive-side SimuCam sync decoder: timestamps filtered pulse edges, classifies
// master/normal pulses, tracks cycle position and reports period/lock/errors.
module sync_in_decoder
    import sync_in_decoder_pkg::*;
#(
    parameter bit          ACTIVE_HIGH      = 1'b1,
    parameter int unsigned FILTER_LEN       = 4,
    parameter int unsigned MASTER_MIN_CYC   = 1500000,
    parameter int unsigned PULSES_PER_CYCLE = 4,
    parameter int unsigned TIMEOUT_CYC      = 400000000,
    parameter int unsigned CNT_W            = 32
) (
    input  logic                   clk50_clk,
    input  logic                   rst_reset_n,
    input  logic                   enable_i,
    input  logic                   err_clear_i,
    input  logic                   sync_in,
    output logic                   sync_pulse_o,
    output logic                   pulse_end_o,
    output logic                   master_o,
    output logic [PULSE_NUM_W-1:0] pulse_num_o,
    output logic [CNT_W-1:0]       width_o,
    output logic [CNT_W-1:0]       period_o,
    output logic                   period_valid_o,
    output logic                   locked_o,
    output logic                   err_timeout_o,
    output logic                   err_master_o
);

    localparam logic [CNT_W-1:0]       CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]       MASTER_MIN  = CNT_W'(MASTER_MIN_CYC);
    localparam logic [CNT_W-1:0]       TIMEOUT     = CNT_W'(TIMEOUT_CYC);
    localparam logic [PULSE_NUM_W-1:0] PPC         = PULSE_NUM_W'(PULSES_PER_CYCLE);
    localparam logic [1:0]             SETTLE_DONE = 2'd2;

    logic flt_level;
    logic flt_rise;
    logic flt_fall;
    logic flt_stable;

    state_t                 state_q, state_d;
    logic [1:0]             settle_q, settle_d;
    logic                   have_edge_q, have_edge_d;
    logic [CNT_W-1:0]       width_cnt_q, width_cnt_d;
    logic [CNT_W-1:0]       period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]       width_inc, period_inc;
    logic [PULSE_NUM_W-1:0] pulse_num_inc;
    logic                   is_master, timeout_hit;

    logic                   sync_pulse_d, pulse_end_d, master_d;
    logic [PULSE_NUM_W-1:0] pulse_num_d;
    logic [CNT_W-1:0]       width_d, period_d;
    logic                   period_valid_d, locked_d;
    logic                   err_timeout_d, err_master_d;
    logic                   timeout_set, master_err_set;

    sync_in_filter #(
        .ACTIVE_HIGH (ACTIVE_HIGH),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filter (
        .clk      (clk50_clk),
        .rst_n    (rst_reset_n),
        .sync_in  (sync_in),
        .level_o  (flt_level),
        .rise_o   (flt_rise),
        .fall_o   (flt_fall),
        .stable_c (flt_stable)
    );

    assign width_inc     = CNT_W'(sat_inc(SAT_W'(width_cnt_q), SAT_W'(CNT_MAX)));
    assign period_inc    = CNT_W'(sat_inc(SAT_W'(period_cnt_q), SAT_W'(CNT_MAX)));
    assign pulse_num_inc = pulse_num_o + PULSE_NUM_W'(1);
    assign is_master     = (width_cnt_q >= MASTER_MIN);
    assign timeout_hit   = (period_cnt_q >= TIMEOUT);

    // State and output registers.
    always_ff @(posedge clk50_clk) begin
        if (!rst_reset_n) begin
            state_q        <= IDLE_WAIT;
            settle_q       <= '0;
            have_edge_q    <= 1'b0;
            width_cnt_q    <= '0;
            period_cnt_q   <= '0;
            sync_pulse_o   <= 1'b0;
            pulse_end_o    <= 1'b0;
            master_o       <= 1'b0;
            pulse_num_o    <= '0;
            width_o        <= '0;
            period_o       <= '0;
            period_valid_o <= 1'b0;
            locked_o       <= 1'b0;
            err_timeout_o  <= 1'b0;
            err_master_o   <= 1'b0;
        end else begin
            state_q        <= state_d;
            settle_q       <= settle_d;
            have_edge_q    <= have_edge_d;
            width_cnt_q    <= width_cnt_d;
            period_cnt_q   <= period_cnt_d;
            sync_pulse_o   <= sync_pulse_d;
            pulse_end_o    <= pulse_end_d;
            master_o       <= master_d;
            pulse_num_o    <= pulse_num_d;
            width_o        <= width_d;
            period_o       <= period_d;
            period_valid_o <= period_valid_d;
            locked_o       <= locked_d;
            err_timeout_o  <= err_timeout_d;
            err_master_o   <= err_master_d;
        end
    end

    // Next-state, counters, cycle tracking and error flags.
    always_comb begin
        state_d        = state_q;
        settle_d       = '0;
        have_edge_d    = have_edge_q;
        width_cnt_d    = width_inc;
        period_cnt_d   = period_inc;
        sync_pulse_d   = 1'b0;
        pulse_end_d    = 1'b0;
        master_d       = master_o;
        pulse_num_d    = pulse_num_o;
        width_d        = width_o;
        period_d       = period_o;
        period_valid_d = period_valid_o;
        locked_d       = locked_o;
        timeout_set    = 1'b0;
        master_err_set = 1'b0;

        if (!enable_i) begin
            state_d        = IDLE_WAIT;
            have_edge_d    = 1'b0;
            width_cnt_d    = '0;
            period_cnt_d   = '0;
            locked_d       = 1'b0;
            period_valid_d = 1'b0;
        end else if ((state_q != IDLE_WAIT) && timeout_hit) begin
            timeout_set    = 1'b1;
            state_d        = IDLE_WAIT;
            have_edge_d    = 1'b0;
            width_cnt_d    = '0;
            period_cnt_d   = '0;
            locked_d       = 1'b0;
            period_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE_WAIT: begin
                    // Three quiet samples let a raw level present at reset reach stage 2.
                    have_edge_d  = 1'b0;
                    width_cnt_d  = '0;
                    period_cnt_d = '0;
                    if (flt_stable && !flt_level) begin
                        if (settle_q == SETTLE_DONE) begin
                            state_d = BLANK;
                        end else begin
                            settle_d = settle_q + 2'd1;
                        end
                    end
                end
                BLANK: begin
                    if (flt_rise) begin
                        sync_pulse_d = 1'b1;
                        width_cnt_d  = CNT_W'(1);
                        period_cnt_d = CNT_W'(1);
                        have_edge_d  = 1'b1;
                        state_d      = PULSE;
                        if (have_edge_q) begin
                            period_d       = period_cnt_q;
                            period_valid_d = 1'b1;
                        end
                    end
                end
                PULSE: begin
                    if (flt_fall) begin
                        pulse_end_d = 1'b1;
                        width_d     = width_cnt_q;
                        master_d    = is_master;
                        state_d     = BLANK;
                        if (is_master) begin
                            pulse_num_d = '0;
                            locked_d    = 1'b1;
                        end else if (locked_o && (pulse_num_inc == PPC)) begin
                            master_err_set = 1'b1;
                            locked_d       = 1'b0;
                            pulse_num_d    = '0;
                        end else begin
                            pulse_num_d = pulse_num_inc;
                        end
                    end
                end
                default: state_d = IDLE_WAIT;
            endcase
        end

        err_timeout_d = timeout_set | (err_timeout_o & ~err_clear_i);
        err_master_d  = master_err_set | (err_master_o & ~err_clear_i);
    end

endmodule

// File: tb/tb_sync_in_decoder.sv
// Directed self-checking bench for sync_in_decoder (FILTER_LEN=2, MASTER_MIN_CYC=20,
// PULSES_PER_CYCLE=4, TIMEOUT_CYC=1000).
module tb_sync_in_decoder;

    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             err_clear;
    logic             sync_raw;
    logic             sync_pulse_o;
    logic             pulse_end_o;
    logic             master_o;
    logic [7:0]       pulse_num_o;
    logic [CNT_W-1:0] width_o;
    logic [CNT_W-1:0] period_o;
    logic             period_valid_o;
    logic             locked_o;
    logic             err_timeout_o;
    logic             err_master_o;

    int         checks   = 0;
    int         failures = 0;
    int         sp_cnt   = 0;
    int         pe_cnt   = 0;
    logic       last_master = 1'b0;
    logic [7:0] last_num    = 8'd0;
    logic [31:0] last_width = 32'd0;
    int         pe_exp;
    int         sp_exp;

    always #10 clk = ~clk;

    sync_in_decoder #(
        .ACTIVE_HIGH      (1'b1),
        .FILTER_LEN       (2),
        .MASTER_MIN_CYC   (20),
        .PULSES_PER_CYCLE (4),
        .TIMEOUT_CYC      (1000),
        .CNT_W            (CNT_W)
    ) dut (
        .clk50_clk      (clk),
        .rst_reset_n    (rst_n),
        .enable_i       (enable),
        .err_clear_i    (err_clear),
        .sync_in        (sync_raw),
        .sync_pulse_o   (sync_pulse_o),
        .pulse_end_o    (pulse_end_o),
        .master_o       (master_o),
        .pulse_num_o    (pulse_num_o),
        .width_o        (width_o),
        .period_o       (period_o),
        .period_valid_o (period_valid_o),
        .locked_o       (locked_o),
        .err_timeout_o  (err_timeout_o),
        .err_master_o   (err_master_o)
    );

    // Strobe recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (sync_pulse_o) sp_cnt <= sp_cnt + 1;
        if (pulse_end_o) begin
            pe_cnt      <= pe_cnt + 1;
            last_master <= master_o;
            last_num    <= pulse_num_o;
            last_width  <= width_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic raw_pulse(input int hi, input int lo);
        sync_raw = 1'b1;
        repeat (hi) tick();
        sync_raw = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic check_end(input string tag, input int exp_pe, input logic exp_master,
                             input logic [7:0] exp_num, input logic [31:0] exp_width);
        check({tag, "_pe_cnt"}, 32'(pe_cnt), 32'(exp_pe));
        check({tag, "_master"}, 32'(last_master), 32'(exp_master));
        check({tag, "_num"}, 32'(last_num), 32'(exp_num));
        check({tag, "_width"}, last_width, exp_width);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sync_pulse"}, 32'(sync_pulse_o), 32'd0);
        check({tag, "_pulse_end"}, 32'(pulse_end_o), 32'd0);
        check({tag, "_master"}, 32'(master_o), 32'd0);
        check({tag, "_pulse_num"}, 32'(pulse_num_o), 32'd0);
        check({tag, "_width"}, width_o, 32'd0);
        check({tag, "_period"}, period_o, 32'd0);
        check({tag, "_period_valid"}, 32'(period_valid_o), 32'd0);
        check({tag, "_locked"}, 32'(locked_o), 32'd0);
        check({tag, "_err_timeout"}, 32'(err_timeout_o), 32'd0);
        check({tag, "_err_master"}, 32'(err_master_o), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        err_clear = 1'b0;
        sync_raw  = 1'b0;
        pe_exp    = 0;
        sp_exp    = 0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        repeat (5) tick();

        // Nominal cycle 1: strobe latency on the master's leading edge
        sync_raw = 1'b1;
        repeat (5) tick();
        check("lat_before", 32'(sync_pulse_o), 32'd0);
        tick();
        check("lat_strobe", 32'(sync_pulse_o), 32'd1);
        repeat (24) tick();
        sync_raw = 1'b0;
        repeat (170) tick();
        pe_exp = 1; sp_exp = 1;
        check_end("c1_m", pe_exp, 1'b1, 8'd0, 32'd30);
        check("c1_m_locked", 32'(locked_o), 32'd1);
        check("c1_m_pv", 32'(period_valid_o), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            raw_pulse(10, 190);
            pe_exp++; sp_exp++;
            check_end($sformatf("c1_n%0d", i), pe_exp, 1'b0, 8'(i), 32'd10);
            check($sformatf("c1_n%0d_period", i), period_o, 32'd200);
            check($sformatf("c1_n%0d_pv", i), 32'(period_valid_o), 32'd1);
        end

        // Nominal cycle 2
        raw_pulse(30, 170);
        pe_exp++; sp_exp++;
        check_end("c2_m", pe_exp, 1'b1, 8'd0, 32'd30);
        for (int i = 1; i <= 3; i++) begin
            raw_pulse(10, 190);
            pe_exp++; sp_exp++;
            check_end($sformatf("c2_n%0d", i), pe_exp, 1'b0, 8'(i), 32'd10);
            check($sformatf("c2_n%0d_locked", i), 32'(locked_o), 32'd1);
        end
        check("c2_sp_cnt", 32'(sp_cnt), 32'(sp_exp));

        // Glitch in blank, then a 2-clk pulse
        raw_pulse(30, 80);
        pe_exp++; sp_exp++;
        check_end("g_m", pe_exp, 1'b1, 8'd0, 32'd30);
        sync_raw = 1'b1;
        tick();
        sync_raw = 1'b0;
        repeat (89) tick();
        check("glitch_no_strobe", 32'(sp_cnt), 32'(sp_exp));
        raw_pulse(2, 198);
        pe_exp++; sp_exp++;
        check("g2_sp_cnt", 32'(sp_cnt), 32'(sp_exp));
        check_end("g2", pe_exp, 1'b0, 8'd1, 32'd2);
        check("g2_period", period_o, 32'd200);

        // Missing master: 4th normal since lock
        raw_pulse(10, 190);
        raw_pulse(10, 190);
        pe_exp += 2; sp_exp += 2;
        check_end("mm_n3", pe_exp, 1'b0, 8'd3, 32'd10);
        check("mm_n3_err", 32'(err_master_o), 32'd0);
        raw_pulse(10, 190);
        pe_exp++; sp_exp++;
        check_end("mm_n4", pe_exp, 1'b0, 8'd0, 32'd10);
        check("mm_n4_err", 32'(err_master_o), 32'd1);
        check("mm_n4_locked", 32'(locked_o), 32'd0);
        raw_pulse(30, 170);
        pe_exp++; sp_exp++;
        check_end("mm_relock", pe_exp, 1'b1, 8'd0, 32'd30);
        check("mm_relock_locked", 32'(locked_o), 32'd1);
        check("mm_relock_err", 32'(err_master_o), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("mm_cleared", 32'(err_master_o), 32'd0);

        // Timeout with input stuck low
        check("tol_pv_before", 32'(period_valid_o), 32'd1);
        repeat (1000) tick();
        check("tol_err", 32'(err_timeout_o), 32'd1);
        check("tol_locked", 32'(locked_o), 32'd0);
        check("tol_pv", 32'(period_valid_o), 32'd0);
        check("tol_err_master", 32'(err_master_o), 32'd0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("tol_cleared", 32'(err_timeout_o), 32'd0);

        // Timeout with input stuck high
        raw_pulse(30, 170);
        pe_exp++; sp_exp++;
        check_end("toh_m1", pe_exp, 1'b1, 8'd0, 32'd30);
        check("toh_m1_pv", 32'(period_valid_o), 32'd0);
        raw_pulse(30, 170);
        pe_exp++; sp_exp++;
        check("toh_m2_pv", 32'(period_valid_o), 32'd1);
        check("toh_m2_period", period_o, 32'd200);
        sync_raw = 1'b1;
        repeat (1100) tick();
        sp_exp++;
        check("toh_err", 32'(err_timeout_o), 32'd1);
        check("toh_locked", 32'(locked_o), 32'd0);
        check("toh_pv", 32'(period_valid_o), 32'd0);
        sync_raw = 1'b0;
        repeat (20) tick();
        check("toh_no_end", 32'(pe_cnt), 32'(pe_exp));
        check("toh_sp_cnt", 32'(sp_cnt), 32'(sp_exp));
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("toh_cleared", 32'(err_timeout_o), 32'd0);

        // Error set and clear in the same cycle
        raw_pulse(30, 170);
        for (int i = 1; i <= 3; i++) raw_pulse(10, 190);
        pe_exp += 4; sp_exp += 4;
        check_end("sc_n3", pe_exp, 1'b0, 8'd3, 32'd10);
        sync_raw = 1'b1;
        repeat (10) tick();
        sync_raw = 1'b0;
        repeat (5) tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("sc_pulse_end", 32'(pulse_end_o), 32'd1);
        check("sc_err_master", 32'(err_master_o), 32'd1);
        check("sc_locked", 32'(locked_o), 32'd0);
        repeat (185) tick();
        pe_exp++; sp_exp++;

        // enable_i dropped mid-pulse
        raw_pulse(30, 170);
        pe_exp++; sp_exp++;
        sync_raw = 1'b1;
        repeat (15) tick();
        sp_exp++;
        check("en_locked_before", 32'(locked_o), 32'd1);
        enable = 1'b0;
        tick();
        check("en_locked", 32'(locked_o), 32'd0);
        check("en_pv", 32'(period_valid_o), 32'd0);
        sync_raw = 1'b0;
        repeat (20) tick();
        check("en_no_end", 32'(pe_cnt), 32'(pe_exp));
        check("en_err_kept", 32'(err_master_o), 32'd1);
        check("en_width_kept", width_o, 32'd30);
        check("en_period_kept", period_o, 32'd200);
        enable = 1'b1;
        repeat (5) tick();

        // Reset mid-pulse, released with the input already active
        sync_raw = 1'b1;
        repeat (10) tick();
        sp_exp++;
        check("rst_sp_cnt", 32'(sp_cnt), 32'(sp_exp));
        rst_n = 1'b0;
        repeat (3) tick();
        check_zero("mid_reset");
        rst_n = 1'b1;
        repeat (30) tick();
        check("start_high_no_strobe", 32'(sp_cnt), 32'(sp_exp));
        check("start_high_no_end", 32'(pe_cnt), 32'(pe_exp));
        sync_raw = 1'b0;
        repeat (30) tick();
        raw_pulse(10, 50);
        sp_exp++; pe_exp++;
        check("start_sp_cnt", 32'(sp_cnt), 32'(sp_exp));
        check_end("start", pe_exp, 1'b0, 8'd1, 32'd10);
        check("start_pv", 32'(period_valid_o), 32'd0);
        check("start_locked", 32'(locked_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_in_decoder.md
Name: sync_in_decoder

Overview:
- Receive-side decoder for the SimuCam external sync signal, i.e. the signal produced by the sync generator on `sync_out_conduit` and consumed on `sync_in_conduit`.
- Synchronises and deglitches the raw input, then timestamps leading and trailing edges.
- Classifies each pulse as master or normal by its width, and tracks the pulse position in the sync cycle.
- Reports period, width, lock and error status to the sync/CCD-timing logic and to a CSR wrapper.

Parameters:
- ACTIVE_HIGH, 1, 1 means the active pulse level is '1'; 0 means the active level is '0'.
- FILTER_LEN, 4, number of consecutive equal synchronised samples required to accept a level change (1..255).
- MASTER_MIN_CYC, 1500000, minimum pulse width in clocks for a pulse to classify as master.
- PULSES_PER_CYCLE, 4, number of pulses per sync cycle, master included (2..255).
- TIMEOUT_CYC, 400000000, maximum number of clocks allowed without a leading edge.
- CNT_W, 32, width of the width and period counters.

Ports:
- clk50_clk  in  1  system clock, 50 MHz.
- rst_reset_n  in  1  reset; synchronous, active-low.
- enable_i  in  1  decoder enable.
- err_clear_i  in  1  single-cycle clear of the sticky error flags.
- sync_in  in  1  raw asynchronous sync input.
- sync_pulse_o  out  1  one-cycle strobe on an accepted leading edge.
- pulse_end_o  out  1  one-cycle strobe on an accepted trailing edge; qualifies master_o, width_o and pulse_num_o.
- master_o  out  1  the pulse just ended was a master pulse.
- pulse_num_o  out  8  position of the ended pulse in the cycle; master = 0.
- width_o  out  CNT_W  width of the last pulse in clocks.
- period_o  out  CNT_W  clocks between the last two leading edges.
- period_valid_o  out  1  period_o holds a real measurement.
- locked_o  out  1  decoder is aligned to the cycle.
- err_timeout_o  out  1  sticky: timeout occurred.
- err_master_o  out  1  sticky: master missing or out of place.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE_WAIT, and the filtered level is inactive.
- Input conditioning:
  - Two-flop synchroniser, then a filter counter.
  - The filtered level changes only after FILTER_LEN consecutive stage-2 samples differ from it.
  - A raw change sampled at edge k produces its strobe at edge k+FILTER_LEN+3. Glitches shorter than FILTER_LEN clocks are ignored.
- FSM states IDLE_WAIT, BLANK, PULSE:
  - IDLE_WAIT: wait for the filtered level to be inactive, then go to BLANK. An input that is already active at reset or enable is never treated as a leading edge.
  - BLANK: on a filtered leading edge, pulse sync_pulse_o, clear the width counter and go to PULSE.
    - If a previous leading edge exists since entering BLANK from IDLE_WAIT: period_o takes the period counter value and period_valid_o is set to 1.
    - The period counter then restarts at 1.
  - PULSE: on a filtered trailing edge, pulse pulse_end_o, load width_o, set master_o = (width >= MASTER_MIN_CYC) and go to BLANK.
- Width and period counters increment every clock and saturate at 2^CNT_W-1; they never wrap.
- Cycle tracking, evaluated at the trailing edge:
  - Master pulse: pulse_num is 0 and locked_o is set to 1.
  - Normal pulse while locked: pulse_num increments.
  - If the incremented value equals PULSES_PER_CYCLE: set err_master_o, clear locked_o and force pulse_num to 0.
  - Normal pulse while unlocked: pulse_num increments modulo 256 and no error is raised.
- Timeout:
  - In BLANK or PULSE, if the period counter reaches TIMEOUT_CYC: set err_timeout_o, clear locked_o and period_valid_o, and go to IDLE_WAIT.
  - This covers both an input stuck active and an input stuck inactive.
- enable_i low:
  - Next state is IDLE_WAIT; all strobes are 0.
  - locked_o and period_valid_o are cleared and the counters are zeroed.
  - Sticky errors, width_o and period_o keep their values.
- err_clear_i clears both sticky errors. When an error set and err_clear_i occur in the same cycle, the set wins.
- Reset in mid-pulse returns to the reset state. The in-flight pulse is discarded with no strobe.

Decomposition:
- Package sync_in_decoder_pkg:
  - state enum {IDLE_WAIT, BLANK, PULSE};
  - helper function for a counter-width clog2;
  - saturating-increment function.
- Sub-module sync_in_filter: synchroniser, glitch filter and edge detect. It outputs the filtered level, rise_o and fall_o.

Test Plan:
Simulation parameters for all scenarios: FILTER_LEN=2, MASTER_MIN_CYC=20, PULSES_PER_CYCLE=4, TIMEOUT_CYC=1000, ACTIVE_HIGH=1.
- Nominal cycle: master 30 clk, then 3 normals of 10 clk, period 200 clk, repeated twice.
  - Expected: sync_pulse_o 5 clk after each raw rise.
  - Expected per pulse_end_o: master_o=1/0/0/0, pulse_num_o=0/1/2/3, width_o=30/10/10/10.
  - Expected: period_o=200 from the second edge, locked_o=1 after the first master.
- Glitch: a 1-clk high blip during blank.
  - Expected: no strobe, period unaffected.
  - A 2-clk high pulse produces a strobe with width_o=2.
- Missing master: lock, then 4 normal pulses in sequence.
  - Expected: the 4th normal sets err_master_o and drops locked_o, pulse_num_o=0.
  - A following master relocks; err_master_o stays 1 until err_clear_i.
- Timeout: after lock, hold sync_in low for 1000 clk.
  - Expected: err_timeout_o=1, locked_o=0, period_valid_o=0.
  - Repeat with sync_in held high: same result.
- Startup active: release reset with sync_in high, then drop it and pulse again.
  - Expected: no strobe for the initial high; the first strobe comes on the later rise, with period_valid_o still 0.
- Same-cycle events: err_clear_i in the same cycle as an error set leaves the flag at 1.
  - Deasserting enable_i mid-pulse gives no pulse_end_o, and locked_o goes to 0 on the next clock.
